// File: rtl/bright_pkg.sv
// bright_pkg: shared types and constants for the brightness frame sequencer.
//   state_t     - frame sequencer states
//   PIX_W       - pixel index width for the default 640x480 frame
//   OFS_W       - signed per-channel offset width
//   PIX_BITS    - packed {R,G,B} pixel width
//   ent_t       - output FIFO entry {sof, eof, pixel}
//   ramp_toward - moves an offset toward a target by at most a given step
package bright_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int PIX_W        = $clog2(H_ACTIVE_DEF * V_ACTIVE_DEF);
   localparam int OFS_W        = 9;
   localparam int PIX_BITS     = 24;
   localparam int ENT_W        = PIX_BITS + 2;

   typedef struct packed {
      logic                sof;
      logic                eof;
      logic [PIX_BITS-1:0] pixel;
   } ent_t;

   // Step cur toward tgt, landing exactly on tgt once the gap fits in one step.
   function automatic logic signed [OFS_W-1:0] ramp_toward(
      input logic signed [OFS_W-1:0] cur,
      input logic signed [OFS_W-1:0] tgt,
      input int                      step
   );
      int diff_v;
      int nxt_v;
      diff_v = int'(tgt) - int'(cur);
      if (diff_v > step) begin
         nxt_v = int'(cur) + step;
      end else if (diff_v < -step) begin
         nxt_v = int'(cur) - step;
      end else begin
         nxt_v = int'(tgt);
      end
      return nxt_v[OFS_W-1:0];
   endfunction

endpackage

// File: rtl/bright_out_fifo.sv
// bright_out_fifo: 2-entry synchronous FIFO holding datapath results.
// slot0 is always the head, so the head outputs come straight from a register.
//   clk, rst (async active-low), flush (drop all entries),
//   push/din (write), pop (remove head), head (oldest entry), occ (0..2)
module bright_out_fifo
   import bright_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [ENT_W-1:0] din,
   output logic [ENT_W-1:0] head,
   output logic [1:0]       occ
);

   logic [ENT_W-1:0] slot0_r;
   logic [ENT_W-1:0] slot1_r;
   logic [1:0]       occ_r;
   logic             do_pop_s;

   assign do_pop_s = pop && (occ_r != 2'd0);
   assign head     = slot0_r;
   assign occ      = occ_r;

   // Storage and occupancy; a pop shifts slot1 down into the head slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot0_r <= {ENT_W{1'b0}};
         slot1_r <= {ENT_W{1'b0}};
         occ_r   <= 2'd0;
      end else if (flush) begin
         occ_r <= 2'd0;
      end else begin
         case ({push, do_pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  slot0_r <= din;
                  occ_r   <= 2'd1;
               end else if (occ_r == 2'd1) begin
                  slot1_r <= din;
                  occ_r   <= 2'd2;
               end else begin
                  occ_r <= occ_r;
               end
            end
            2'b01: begin
               slot0_r <= slot1_r;
               occ_r   <= occ_r - 2'd1;
            end
            2'b11: begin
               if (occ_r == 2'd1) begin
                  slot0_r <= din;
               end else begin
                  slot0_r <= slot1_r;
                  slot1_r <= din;
               end
            end
            default: begin
               occ_r <= occ_r;
            end
         endcase
      end
   end

endmodule

// File: rtl/bright_frame_ctrl.sv
// bright_frame_ctrl: frame sequencer for the external 1-cycle RGB brightness datapath.
//   start/abort     - frame control pulses (abort has priority)
//   cfg_we, cfg_*   - shadow offset writes, committed to dp_r/g/b in LOAD
//   s_valid/s_ready/s_pixel - input pixel stream
//   dp_pixel, dp_r/g/b, dp_bright - datapath interface (result one cycle after accept)
//   m_valid/m_ready/m_pixel/m_sof/m_eof - output stream from a 2-entry FIFO
//   busy, done, frame_cnt - status
// Build option: BRIGHT_CTRL_RAMP_EN makes LOAD move each offset toward its
// shadow by at most RAMP_STEP instead of copying it.
module bright_frame_ctrl
   import bright_pkg::*;
#(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int RAMP_STEP = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic                    cfg_we,
   input  logic signed [OFS_W-1:0] cfg_r,
   input  logic signed [OFS_W-1:0] cfg_g,
   input  logic signed [OFS_W-1:0] cfg_b,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [PIX_BITS-1:0]     s_pixel,
   output logic [PIX_BITS-1:0]     dp_pixel,
   output logic signed [OFS_W-1:0] dp_r,
   output logic signed [OFS_W-1:0] dp_g,
   output logic signed [OFS_W-1:0] dp_b,
   input  logic [PIX_BITS-1:0]     dp_bright,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [PIX_BITS-1:0]     m_pixel,
   output logic                    m_sof,
   output logic                    m_eof,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             frame_cnt
);

   localparam int FRAME_W = $clog2(H_ACTIVE * V_ACTIVE);
   localparam int CNT_W   = ((FRAME_W > PIX_W) ? FRAME_W : PIX_W) + 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(H_ACTIVE * V_ACTIVE - 1);

   state_t                  state_r, state_nxt_s;
   logic [CNT_W-1:0]        in_cnt_r;
   logic                    inflight_r, infl_sof_r, infl_eof_r;
   logic signed [OFS_W-1:0] shd_red_r, shd_grn_r, shd_blu_r;
   logic signed [OFS_W-1:0] act_red_r, act_grn_r, act_blu_r;
   logic [15:0]             frame_cnt_r;
   logic [1:0]              occ_s;
   ent_t                    head_s;
   logic                    accept_s, pop_s, eof_pop_s, push_s;
   logic [2:0]              level_s;

`ifndef BRIGHT_CTRL_RAMP_EN
   logic unused_ramp_s;
   assign unused_ramp_s = (RAMP_STEP != 0);
`endif

   assign m_valid   = (occ_s != 2'd0);
   assign m_pixel   = head_s.pixel;
   assign m_sof     = m_valid && head_s.sof;
   assign m_eof     = m_valid && head_s.eof;
   assign pop_s     = m_valid && m_ready;
   assign eof_pop_s = pop_s && head_s.eof;

   // Entries already owed to the FIFO after this cycle's pop; one free slot is needed to accept.
   assign level_s   = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
   assign s_ready   = (state_r == RUN) && (level_s <= 3'd1);
   assign accept_s  = s_valid && s_ready;
   assign push_s    = inflight_r && !abort;

   assign dp_pixel  = s_pixel;
   assign dp_r      = act_red_r;
   assign dp_g      = act_grn_r;
   assign dp_b      = act_blu_r;
   assign busy      = (state_r != IDLE);
   assign done      = (state_r == DRAIN) && eof_pop_s && !abort;
   assign frame_cnt = frame_cnt_r;

   bright_out_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (abort),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({infl_sof_r, infl_eof_r, dp_bright}),
      .head  (head_s),
      .occ   (occ_s)
   );

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE:    state_nxt_s = start ? LOAD : IDLE;
            LOAD:    state_nxt_s = RUN;
            RUN:     state_nxt_s = (accept_s && (in_cnt_r == LAST_IDX)) ? DRAIN : RUN;
            DRAIN:   state_nxt_s = eof_pop_s ? IDLE : DRAIN;
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Input pixel index and the in-flight tag that follows an accept by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cnt_r   <= {CNT_W{1'b0}};
         inflight_r <= 1'b0;
         infl_sof_r <= 1'b0;
         infl_eof_r <= 1'b0;
      end else begin
         inflight_r <= accept_s && !abort;
         if (state_r == LOAD) begin
            in_cnt_r <= {CNT_W{1'b0}};
         end else if (accept_s) begin
            in_cnt_r <= in_cnt_r + CNT_W'(1);
         end
         if (accept_s) begin
            infl_sof_r <= (in_cnt_r == {CNT_W{1'b0}});
            infl_eof_r <= (in_cnt_r == LAST_IDX);
         end
      end
   end

   // Shadow offsets take writes any time; active offsets change only in LOAD,
   // so a write in the LOAD cycle lands in the shadow after the commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shd_red_r <= 9'sd0;
         shd_grn_r <= 9'sd0;
         shd_blu_r <= 9'sd0;
         act_red_r <= 9'sd0;
         act_grn_r <= 9'sd0;
         act_blu_r <= 9'sd0;
      end else begin
         if (cfg_we) begin
            shd_red_r <= cfg_r;
            shd_grn_r <= cfg_g;
            shd_blu_r <= cfg_b;
         end
         if ((state_r == LOAD) && !abort) begin
`ifdef BRIGHT_CTRL_RAMP_EN
            act_red_r <= ramp_toward(act_red_r, shd_red_r, RAMP_STEP);
            act_grn_r <= ramp_toward(act_grn_r, shd_grn_r, RAMP_STEP);
            act_blu_r <= ramp_toward(act_blu_r, shd_blu_r, RAMP_STEP);
`else
            act_red_r <= shd_red_r;
            act_grn_r <= shd_grn_r;
            act_blu_r <= shd_blu_r;
`endif
         end
      end
   end

   // Completed-frame counter, stepped on the edge that pops the last pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt_r <= 16'd0;
      end else if (done) begin
         frame_cnt_r <= frame_cnt_r + 16'd1;
      end
   end

endmodule
